// File: rtl/gate_equiv_sequencer.sv
// Exhaustive input sweeper that drives one vector into a gate/reference pair,
// lets it settle, compares the two outputs and keeps a mismatch summary.
module gate_equiv_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            dut_s,
    input  logic            ref_s,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_vld
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] VEC_ZERO = {N_IN{1'b0}};
    localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ZERO = {(N_IN+1){1'b0}};
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN+1)'(1);

    state_t            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ffv_q, ffv_d;
    logic              vld_q, vld_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              mismatch_s;

    // Next-state and next-result logic; status flags derive from the next state so they stay registered.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        vld_d      = vld_q;
        mismatch_s = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SETTLE;
                    vec_d   = VEC_ZERO;
                    cnt_d   = 4'd0;
                    err_d   = ERR_ZERO;
                    ffv_d   = VEC_ZERO;
                    vld_d   = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_COMPARE: begin
                // Case inequality so an unknown output is reported as a failure.
                mismatch_s = (dut_s !== ref_s);
                if (mismatch_s) begin
                    err_d = err_q + ERR_ONE;
                    if (!vld_q) begin
                        ffv_d = vec_q;
                        vld_d = 1'b1;
                    end else begin
                        vld_d = vld_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (vec_q == VEC_LAST) begin
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + VEC_ONE;
                    cnt_d   = 4'd0;
                    state_d = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_SETTLE) || (state_d == S_COMPARE);
        done_d = (state_d == S_DONE);
        pass_d = done_d && (err_d == ERR_ZERO);
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= VEC_ZERO;
            cnt_q   <= 4'd0;
            err_q   <= ERR_ZERO;
            ffv_q   <= VEC_ZERO;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign vec            = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;
    assign first_fail_vld = vld_q;

endmodule

// File: tb/tb_gate_equiv_sequencer.sv
// Directed bench: two sequencer instances (2-input/SETTLE=1 and 3-input/SETTLE=3)
// each driving a small gate pair whose faults are selected by the test mode.
module tb_gate_equiv_sequencer;

    logic clk;
    logic rst_n;
    logic start_a, start_b;
    int   mode;

    logic [1:0] a_vec;
    logic       a_busy, a_done, a_pass, a_vld;
    logic [2:0] a_err;
    logic [1:0] a_ffv;
    logic       a_dut, a_ref;

    logic [2:0] b_vec;
    logic       b_busy, b_done, b_pass, b_vld;
    logic [3:0] b_err;
    logic [2:0] b_ffv;
    logic       b_dut, b_ref;

    int n_checks = 0;
    int n_errors = 0;
    int r_vec, r_busy, r_done, r_pass, r_err, r_ffv, r_vld;

    gate_equiv_sequencer #(.N_IN(2), .SETTLE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_s(a_dut), .ref_s(a_ref),
        .vec(a_vec), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err), .first_fail_vec(a_ffv), .first_fail_vld(a_vld)
    );

    gate_equiv_sequencer #(.N_IN(3), .SETTLE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_s(b_dut), .ref_s(b_ref),
        .vec(b_vec), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err), .first_fail_vec(b_ffv), .first_fail_vld(b_vld)
    );

    // Pair A: NAND built from NOR gates against ~(a&b); modes inject faults.
    logic na_s, nb_s, t_s, nand_g_s;
    assign na_s     = ~(a_vec[1] | a_vec[1]);
    assign nb_s     = ~(a_vec[0] | a_vec[0]);
    assign t_s      = ~(na_s | nb_s);
    assign nand_g_s = ~(t_s | t_s);
    assign a_dut    = nand_g_s ^ ((mode == 2 && a_vec == 2'd3) ||
                                  (mode == 3 && (a_vec == 2'd1 || a_vec == 2'd2)));
    assign a_ref    = (mode == 1) ? (a_vec[1] & a_vec[0]) : ~(a_vec[1] & a_vec[0]);

    // Pair B: 3-input parity as sum of products against the reduction XOR.
    logic x01_s;
    assign x01_s = (b_vec[0] & ~b_vec[1]) | (~b_vec[0] & b_vec[1]);
    assign b_dut = ((x01_s & ~b_vec[2]) | (~x01_s & b_vec[2])) ^ (mode == 2 && b_vec == 3'd5);
    assign b_ref = (mode == 1) ? ~(^b_vec) : (^b_vec);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int inst;
        int mode;
        int e_err;
        int e_ffv;
        int e_vld;
        int e_pass;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sample(input int inst);
        if (inst == 0) begin
            r_vec = a_vec; r_busy = a_busy; r_done = a_done; r_pass = a_pass;
            r_err = a_err; r_ffv = a_ffv; r_vld = a_vld;
        end else begin
            r_vec = b_vec; r_busy = b_busy; r_done = b_done; r_pass = b_pass;
            r_err = b_err; r_ffv = b_ffv; r_vld = b_vld;
        end
    endtask

    task automatic set_start(input int inst, input logic v);
        if (inst == 0) start_a = v;
        else           start_b = v;
    endtask

    // One full sweep with a one-cycle start; checks latency, per-cycle vec trace and results.
    task automatic run_sweep(input int inst, input vec_t t);
        int n_in, s, total, last, done_at, trace_bad, exp_vec, keep_err;
        n_in  = (inst == 0) ? 2 : 3;
        s     = (inst == 0) ? 1 : 3;
        total = (1 << n_in) * (s + 1);
        last  = (1 << n_in) - 1;
        mode  = t.mode;
        done_at   = 0;
        trace_bad = 0;
        @(negedge clk);
        set_start(inst, 1'b1);
        @(posedge clk);
        #1;
        set_start(inst, 1'b0);
        for (int k = 1; k <= total + 20; k++) begin
            @(posedge clk);
            #1;
            sample(inst);
            exp_vec = (k / (s + 1) > last) ? last : k / (s + 1);
            if (r_vec != exp_vec) trace_bad++;
            if (r_done == 1) begin
                done_at = k;
                break;
            end
            if (r_busy != 1 || r_pass != 0) trace_bad++;
        end
        chk("done_latency", done_at, total);
        chk("vec_trace_errs", trace_bad, 0);
        chk("err_count", r_err, t.e_err);
        chk("first_fail_vld", r_vld, t.e_vld);
        chk("first_fail_vec", r_ffv, t.e_ffv);
        chk("pass", r_pass, t.e_pass);
        chk("busy_at_done", r_busy, 0);
        keep_err = r_err;
        repeat (3) @(posedge clk);
        #1;
        sample(inst);
        chk("done_stable", r_done * 1000 + r_err * 10 + r_vec, 1000 + keep_err * 10 + last);
    endtask

    vec_t tbl[6];

    initial begin
        int k;
        int done_at;
        tbl[0] = '{inst: 0, mode: 0, e_err: 0, e_ffv: 0, e_vld: 0, e_pass: 1};
        tbl[1] = '{inst: 0, mode: 1, e_err: 4, e_ffv: 0, e_vld: 1, e_pass: 0};
        tbl[2] = '{inst: 0, mode: 2, e_err: 1, e_ffv: 3, e_vld: 1, e_pass: 0};
        tbl[3] = '{inst: 0, mode: 3, e_err: 2, e_ffv: 1, e_vld: 1, e_pass: 0};
        tbl[4] = '{inst: 1, mode: 0, e_err: 0, e_ffv: 0, e_vld: 0, e_pass: 1};
        tbl[5] = '{inst: 1, mode: 2, e_err: 1, e_ffv: 5, e_vld: 1, e_pass: 0};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 0;
        #12;
        sample(0);
        chk("reset_a", r_vec + r_busy + r_done + r_pass + r_err + r_ffv + r_vld, 0);
        sample(1);
        chk("reset_b", r_vec + r_busy + r_done + r_pass + r_err + r_ffv + r_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_sweep(tbl[i].inst, tbl[i]);

        // start held high: one sweep, then a restart on the cycle after done.
        mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        done_at = 0;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (a_done) begin
                done_at = k;
                break;
            end
        end
        chk("held_start_latency", done_at, 8);
        chk("held_start_err", a_err, 4);
        @(posedge clk);
        #1;
        chk("restart_done", a_done, 0);
        chk("restart_busy", a_busy, 1);
        chk("restart_cleared", a_err * 100 + a_vld * 10 + a_vec, 0);
        start_a = 1'b0;
        done_at = 0;
        for (k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (a_done) begin
                done_at = k;
                break;
            end
        end
        chk("restart_latency", done_at, 8);
        chk("restart_err", a_err, 4);

        // Reset mid-sweep while vec=2 is settling.
        mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_state", a_vec * 100 + a_busy * 10 + a_err, 212);
        rst_n = 1'b0;
        #1;
        sample(0);
        chk("reset_abort", r_vec + r_busy + r_done + r_pass + r_err + r_ffv + r_vld, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(0, tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
